// File: rtl/uart_tx_feeder.sv
// Purpose: word FIFO feeding a UART transmitter, one frame in flight, sticky overflow/timeout flags.
// Latency: a word written into an empty idle FIFO launches (DATA_VALID) one edge after the write edge.
// Backpressure: writes are dropped while FULL (sets OVERFLOW); launches wait for BUSY low in IDLE.
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int BUSY_TMO   = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WR_EN,
  input  logic [DATA_WIDTH-1:0]   WR_DATA,
  input  logic                    CLR_ERR,
  input  logic                    BUSY,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic [$clog2(DEPTH):0]  COUNT,
  output logic [DATA_WIDTH-1:0]   P_DATA,
  output logic                    DATA_VALID,
  output logic                    OVERFLOW,
  output logic                    TX_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(BUSY_TMO) + 1;

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(BUSY_TMO - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           count_q, count_d;
  logic                    full_q, full_d;
  logic                    empty_q, empty_d;
  logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
  logic                    dv_q, dv_d;
  logic                    ovf_q, ovf_d;
  logic                    txerr_q, txerr_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    wr_acc;
  logic                    pop;
  logic                    tmo_evt;

  // FIFO bookkeeping: accepted write, pop on launch, next pointers and flags after the edge
  always_comb begin
    wr_acc   = WR_EN && !full_q;
    pop      = (state_q == ST_IDLE) && !empty_q && !BUSY;
    wr_ptr_d = wr_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (count_d == DEPTH_CNT);
    empty_d  = (count_d == '0);
  end

  // Launch/handshake FSM next-state; P_DATA only reloads when leaving IDLE
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    tmo_evt = 1'b0;
    pdata_d = pdata_q;
    dv_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          pdata_d = mem_q[rd_ptr_q[AW-1:0]];
          dv_d    = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tmo_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (BUSY) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // Transmitter never acknowledged: drop the word rather than retry
          tmo_evt = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!BUSY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky error flags: a new error event beats a same-cycle clear
  always_comb begin
    ovf_d   = (WR_EN && full_q) ? 1'b1 : (CLR_ERR ? 1'b0 : ovf_q);
    txerr_d = tmo_evt ? 1'b1 : (CLR_ERR ? 1'b0 : txerr_q);
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      pdata_q  <= '0;
      dv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      txerr_q  <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      pdata_q  <= pdata_d;
      dv_q     <= dv_d;
      ovf_q    <= ovf_d;
      txerr_q  <= txerr_d;
      tmo_q    <= tmo_d;
    end
  end

  // Storage array; contents need no reset since pointers define validity
  always_ff @(posedge CLK) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= WR_DATA;
  end

  assign FULL       = full_q;
  assign EMPTY      = empty_q;
  assign COUNT      = count_q;
  assign P_DATA     = pdata_q;
  assign DATA_VALID = dv_q;
  assign OVERFLOW   = ovf_q;
  assign TX_ERR     = txerr_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Purpose: directed self-checking bench for uart_tx_feeder (DEPTH=8, BUSY_TMO=4).
// Latency: checks taken 2 time units after each rising edge.
// Backpressure: BUSY comes from a manual drive or a simple transmitter model.
module tb_uart_tx_feeder;

  logic       CLK;
  logic       RST;
  logic       WR_EN;
  logic [7:0] WR_DATA;
  logic       CLR_ERR;
  logic       BUSY;
  logic       FULL;
  logic       EMPTY;
  logic [3:0] COUNT;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       OVERFLOW;
  logic       TX_ERR;

  logic       model_en;
  logic       busy_man;
  logic       busy_model;
  int         busy_len;
  int         bcnt;
  logic       dv_s;
  logic       dv_prev;
  int         dv_double;
  logic [7:0] launched [$];

  int pass_cnt;
  int total;

  uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(8), .BUSY_TMO(4)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .CLR_ERR(CLR_ERR),
    .BUSY(BUSY), .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .OVERFLOW(OVERFLOW), .TX_ERR(TX_ERR)
  );

  assign BUSY = model_en ? busy_model : busy_man;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Launch monitor and transmitter model: BUSY rises one cycle after DATA_VALID, holds busy_len cycles
  always @(posedge CLK) begin
    dv_s = (DATA_VALID === 1'b1);
    if (dv_s) begin
      launched.push_back(P_DATA);
      if (dv_prev) dv_double++;
    end
    dv_prev = dv_s;
    #1;
    if (!model_en) begin
      busy_model = 1'b0;
      bcnt = 0;
    end else if (dv_s) begin
      busy_model = 1'b1;
      bcnt = busy_len;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) busy_model = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] d);
    WR_EN = 1'b1;
    WR_DATA = d;
    tick();
    WR_EN = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (EMPTY !== 1'b1) $display("FAIL rst_empty: got %b want 1", EMPTY); else pass_cnt++;
    total++; if (FULL !== 1'b0) $display("FAIL rst_full: got %b want 0", FULL); else pass_cnt++;
    total++; if (COUNT !== 4'd0) $display("FAIL rst_count: got %0d want 0", COUNT); else pass_cnt++;
    total++; if (P_DATA !== 8'h00 || DATA_VALID !== 1'b0) $display("FAIL rst_out: got P_DATA=%h DV=%b want 00/0", P_DATA, DATA_VALID); else pass_cnt++;
    total++; if (OVERFLOW !== 1'b0 || TX_ERR !== 1'b0) $display("FAIL rst_err: got OVF=%b TXE=%b want 0/0", OVERFLOW, TX_ERR); else pass_cnt++;
  endtask

  task automatic test_single();
    int base;
    int bad;
    base = launched.size();
    model_en = 1'b1;
    busy_len = 10;
    write_word(8'hA5);
    total++; if (EMPTY !== 1'b0 || COUNT !== 4'd1 || DATA_VALID !== 1'b0) $display("FAIL single_wr: got EMPTY=%b COUNT=%0d DV=%b want 0/1/0", EMPTY, COUNT, DATA_VALID); else pass_cnt++;
    tick();
    total++; if (DATA_VALID !== 1'b1 || P_DATA !== 8'hA5) $display("FAIL single_launch: got DV=%b P_DATA=%h want 1/a5", DATA_VALID, P_DATA); else pass_cnt++;
    total++; if (EMPTY !== 1'b1 || COUNT !== 4'd0) $display("FAIL single_pop: got EMPTY=%b COUNT=%0d want 1/0", EMPTY, COUNT); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (DATA_VALID !== 1'b0 || P_DATA !== 8'hA5) bad++;
    end
    total++; if (bad !== 0) $display("FAIL single_hold: got %0d bad cycles want 0", bad); else pass_cnt++;
    total++; if (launched.size() !== base + 1) $display("FAIL single_cnt: got %0d launches want 1", launched.size() - base); else pass_cnt++;
  endtask

  task automatic test_overflow();
    int base;
    base = launched.size();
    model_en = 1'b0;
    busy_man = 1'b1;
    for (int i = 1; i <= 8; i++) write_word(8'(i));
    total++; if (FULL !== 1'b1 || COUNT !== 4'd8) $display("FAIL ovf_full: got FULL=%b COUNT=%0d want 1/8", FULL, COUNT); else pass_cnt++;
    total++; if (OVERFLOW !== 1'b0) $display("FAIL ovf_pre: got %b want 0", OVERFLOW); else pass_cnt++;
    write_word(8'hFF);
    total++; if (OVERFLOW !== 1'b1 || COUNT !== 4'd8) $display("FAIL ovf_set: got OVF=%b COUNT=%0d want 1/8", OVERFLOW, COUNT); else pass_cnt++;
    CLR_ERR = 1'b1;
    write_word(8'hEE);
    total++; if (OVERFLOW !== 1'b1) $display("FAIL ovf_clr_race: got %b want 1", OVERFLOW); else pass_cnt++;
    tick();
    CLR_ERR = 1'b0;
    total++; if (OVERFLOW !== 1'b0) $display("FAIL ovf_clr: got %b want 0", OVERFLOW); else pass_cnt++;
    busy_len = 3;
    busy_man = 1'b0;
    model_en = 1'b1;
    for (int c = 0; c < 300 && launched.size() < base + 8; c++) tick();
    for (int c = 0; c < 10; c++) tick();
    total++; if (launched.size() !== base + 8) $display("FAIL ovf_nwords: got %0d want 8", launched.size() - base); else pass_cnt++;
    for (int i = 0; i < 8 && base + i < launched.size(); i++) begin
      total++; if (launched[base+i] !== 8'(i + 1)) $display("FAIL ovf_order[%0d]: got %h want %h", i, launched[base+i], 8'(i + 1)); else pass_cnt++;
    end
    total++; if (EMPTY !== 1'b1) $display("FAIL ovf_drained: got %b want 1", EMPTY); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int base;
    int nxt;
    base = launched.size();
    model_en = 1'b0;
    busy_man = 1'b1;
    for (int i = 0; i < 7; i++) write_word(8'h40 + 8'(i));
    total++; if (COUNT !== 4'd7) $display("FAIL b2b_fill: got %0d want 7", COUNT); else pass_cnt++;
    busy_man = 1'b0;
    write_word(8'h47);
    total++; if (COUNT !== 4'd7 || DATA_VALID !== 1'b1 || P_DATA !== 8'h40) $display("FAIL b2b_same_edge: got COUNT=%0d DV=%b P_DATA=%h want 7/1/40", COUNT, DATA_VALID, P_DATA); else pass_cnt++;
    busy_len = 2;
    model_en = 1'b1;
    nxt = 8;
    for (int c = 0; c < 600 && (nxt < 20 || launched.size() < base + 20); c++) begin
      if (nxt < 20 && FULL === 1'b0) begin
        WR_EN = 1'b1;
        WR_DATA = 8'h40 + 8'(nxt);
        nxt++;
      end else begin
        WR_EN = 1'b0;
      end
      tick();
    end
    WR_EN = 1'b0;
    total++; if (launched.size() !== base + 20) $display("FAIL b2b_nwords: got %0d want 20", launched.size() - base); else pass_cnt++;
    for (int i = 0; i < 20 && base + i < launched.size(); i++) begin
      total++; if (launched[base+i] !== 8'h40 + 8'(i)) $display("FAIL b2b_order[%0d]: got %h want %h", i, launched[base+i], 8'h40 + 8'(i)); else pass_cnt++;
    end
    for (int c = 0; c < 10; c++) tick();
  endtask

  task automatic test_timeout();
    int bad;
    model_en = 1'b0;
    busy_man = 1'b1;
    write_word(8'h11);
    write_word(8'h22);
    busy_man = 1'b0;
    tick();
    total++; if (DATA_VALID !== 1'b1 || P_DATA !== 8'h11) $display("FAIL tmo_launch: got DV=%b P_DATA=%h want 1/11", DATA_VALID, P_DATA); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (TX_ERR !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL tmo_early: got %0d early cycles want 0", bad); else pass_cnt++;
    tick();
    total++; if (TX_ERR !== 1'b1) $display("FAIL tmo_set: got %b want 1", TX_ERR); else pass_cnt++;
    tick();
    total++; if (DATA_VALID !== 1'b1 || P_DATA !== 8'h22) $display("FAIL tmo_next: got DV=%b P_DATA=%h want 1/22", DATA_VALID, P_DATA); else pass_cnt++;
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    total++; if (TX_ERR !== 1'b0) $display("FAIL tmo_clr: got %b want 0", TX_ERR); else pass_cnt++;
    for (int i = 0; i < 8; i++) tick();
    total++; if (TX_ERR !== 1'b1 || EMPTY !== 1'b1) $display("FAIL tmo_second: got TXE=%b EMPTY=%b want 1/1", TX_ERR, EMPTY); else pass_cnt++;
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    model_en = 1'b0;
    busy_man = 1'b1;
    for (int i = 0; i < 4; i++) write_word(8'h51 + 8'(i));
    busy_man = 1'b0;
    tick();
    busy_man = 1'b1;
    tick();
    tick();
    total++; if (COUNT !== 4'd3 || P_DATA !== 8'h51) $display("FAIL mid_pre: got COUNT=%0d P_DATA=%h want 3/51", COUNT, P_DATA); else pass_cnt++;
    do_reset();
    total++; if (EMPTY !== 1'b1 || COUNT !== 4'd0 || P_DATA !== 8'h00 || DATA_VALID !== 1'b0) $display("FAIL mid_rst: got EMPTY=%b COUNT=%0d P_DATA=%h DV=%b want 1/0/00/0", EMPTY, COUNT, P_DATA, DATA_VALID); else pass_cnt++;
    tick();
    tick();
    write_word(8'h3C);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (DATA_VALID !== 1'b0) bad++;
    end
    total++; if (bad !== 0 || EMPTY !== 1'b0) $display("FAIL mid_block: got %0d launches EMPTY=%b want 0/0", bad, EMPTY); else pass_cnt++;
    busy_man = 1'b0;
    tick();
    total++; if (DATA_VALID !== 1'b1 || P_DATA !== 8'h3C) $display("FAIL mid_launch: got DV=%b P_DATA=%h want 1/3c", DATA_VALID, P_DATA); else pass_cnt++;
    tick();
  endtask

  initial begin
    pass_cnt   = 0;
    total      = 0;
    dv_double  = 0;
    dv_prev    = 1'b0;
    bcnt       = 0;
    busy_len   = 10;
    busy_model = 1'b0;
    model_en   = 1'b0;
    busy_man   = 1'b0;
    RST        = 1'b0;
    WR_EN      = 1'b0;
    WR_DATA    = 8'h00;
    CLR_ERR    = 1'b0;
    tick();
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    total++; if (dv_double !== 0) $display("FAIL dv_consecutive: got %0d want 0", dv_double); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Upstream stage of the UART transmit controller: a synchronous FIFO that buffers parallel words from the system side.
- Launches each word into the transmitter with a single-cycle DATA_VALID pulse and holds P_DATA stable for the whole frame.
- Tracks the transmitter BUSY handshake: one frame in flight at a time, no word lost or duplicated.
- Sticky overflow and handshake-timeout error flags.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and P_DATA.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- BUSY_TMO, 4, max cycles in WAIT_BUSY before the launch is declared failed; minimum 2.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- WR_EN  in  1  write request, sampled on CLK edge.
- WR_DATA  in  DATA_WIDTH  word to enqueue.
- CLR_ERR  in  1  clears OVERFLOW and TX_ERR.
- BUSY  in  1  transmitter busy; high for the whole frame.
- FULL  out  1  FIFO full (registered).
- EMPTY  out  1  FIFO empty (registered).
- COUNT  out  log2(DEPTH)+1  stored entries.
- P_DATA  out  DATA_WIDTH  word in flight; registered.
- DATA_VALID  out  1  one-cycle launch strobe; registered.
- OVERFLOW  out  1  sticky: write attempted while FULL.
- TX_ERR  out  1  sticky: BUSY not seen within BUSY_TMO cycles after launch.

Behaviour:
- Reset (RST=1 at an edge): FIFO emptied and pointers zeroed. State IDLE. EMPTY=1, FULL=0, COUNT=0, P_DATA=0, DATA_VALID=0, OVERFLOW=0, TX_ERR=0. Reset mid-frame aborts the in-flight word; BUSY is ignored until IDLE is re-entered.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - Write accepted iff WR_EN=1 and FULL=0 at the edge.
  - Pop occurs only on the IDLE->LAUNCH transition.
  - Simultaneous write and pop: both happen and COUNT is unchanged.
  - A write while FULL is dropped and sets OVERFLOW, even if a pop happens in the same cycle.
  - FULL/EMPTY/COUNT reflect contents after the edge.
- State machine:
  - IDLE: if EMPTY=0 and BUSY=0, then P_DATA<=head word, pop, go LAUNCH. Otherwise stay.
  - LAUNCH: DATA_VALID=1 for exactly this cycle. Go WAIT_BUSY and clear the timeout counter.
  - WAIT_BUSY: if BUSY=1, go WAIT_DONE. Otherwise increment the counter. After BUSY_TMO cycles without BUSY, set TX_ERR and go IDLE; the word is discarded, not retried.
  - WAIT_DONE: stay while BUSY=1. On BUSY=0, go IDLE.
- DATA_VALID is high only in LAUNCH and never in two consecutive cycles.
- P_DATA changes only on the IDLE->LAUNCH transition and holds through WAIT_DONE.
- Latency:
  - Write at edge k into empty FIFO while idle: EMPTY=0 after k; LAUNCH entered at edge k+1; DATA_VALID high in cycle k+1..k+2.
  - Back-to-back words: the next launch happens at the edge after BUSY is sampled low in WAIT_DONE plus one IDLE cycle.
- CLR_ERR=1 clears both sticky flags at the edge. If an error event occurs in the same cycle, the error wins and the flag stays set.
- BUSY high while in IDLE (e.g. after reset mid-frame) blocks launch until it falls.
- COUNT arithmetic: COUNT = wr_ptr - rd_ptr, modulo 2*DEPTH.

Test Plan:
- Reset, write 0xA5 once, BUSY model rises 1 cycle after DATA_VALID and holds 10 cycles -> DATA_VALID single pulse 2 edges after write with P_DATA=0xA5; EMPTY=1 after pop; P_DATA stable until BUSY falls.
- Write 0x01..0x08 back-to-back (DEPTH=8), then a 9th write 0xFF -> FULL=1 after the 8th write; 9th dropped; OVERFLOW=1. Words transmitted in order 0x01..0x08, each exactly once; 0xFF never appears.
- Keep FIFO near full while transmitting; write on the same edge as a pop -> COUNT unchanged; pointer wrap past DEPTH preserves order over 20 words.
- BUSY held 0 after launch -> TX_ERR=1 exactly BUSY_TMO cycles after LAUNCH; next queued word launches. Then CLR_ERR=1 -> TX_ERR=0.
- Assert RST during WAIT_DONE with 3 words queued -> next cycle EMPTY=1, COUNT=0, P_DATA=0, DATA_VALID=0. Hold BUSY high 5 more cycles, then write 0x3C -> launch occurs only after BUSY=0.
- CLR_ERR asserted in the same cycle as an overflowing write -> OVERFLOW remains 1.
